arduino_uart_tx: RTL and testbench

- Port-mapped serial transmitter that sits directly downstream of the MCU output-port register file.
- Captures bytes the RAT MCU writes to the Arduino port ID and buffers them in a small FIFO.
- Shifts them out as 8N1 UART frames on a single TX pin to the Arduino.
- Returns a status byte for the driver's input mux, so firmware can poll before writing.

---
 rtl/arduino_uart_tx_if.sv | 14 +
 rtl/arduino_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_arduino_uart_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arduino_uart_tx_if.sv
// MCU output-port bus as seen by the Arduino UART transmitter.
// Handshake: a write is one rising edge of IO_STRB. PORT_ID and OUT_PORT must
// be stable while IO_STRB is high. IO_STRB may stay high for several CLK
// cycles, and that still counts as a single write. STATUS is a level that the
// driver's input mux may sample at any time.
interface arduino_uart_tx_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] STATUS;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB, input STATUS);
  modport slave  (input PORT_ID, input OUT_PORT, input IO_STRB, output STATUS);
endinterface

// File: rtl/arduino_uart_tx.sv
// Port-mapped 8N1 UART transmitter with a byte FIFO and a pollable status byte.
// STATUS = {4'b0, OVERFLOW, BUSY, FULL, EMPTY}. o_dbg_state exposes the FSM state.
module arduino_uart_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] DATA_ID      = 8'h22,
  parameter logic [7:0] STATUS_ID    = 8'h23
) (
  input  logic              CLK,
  input  logic              RESET_N,
  arduino_uart_tx_if.slave  bus,
  output logic              TX,
  output logic              BUSY,
  output logic [1:0]        o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  state_t        r_state;
  logic          r_tx;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic [15:0]   r_baud;
  logic          r_strb_q;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic          w_evt;
  logic          w_wr_data;
  logic          w_wr_stat;
  logic          w_baud_end;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic [7:0]    w_head;

  // One write event per strobe rising edge, decoded by port ID.
  assign w_evt      = bus.IO_STRB & ~r_strb_q;
  assign w_wr_data  = w_evt && (bus.PORT_ID == DATA_ID);
  assign w_wr_stat  = w_evt && (bus.PORT_ID == STATUS_ID);
  assign w_baud_end = (r_baud == 16'(CLKS_PER_BIT - 1));

  // The FSM pops when idle or at the end of a stop bit. Because of this
  // same-cycle pop, a push into a full FIFO can still be accepted.
  assign w_pop    = !r_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
  assign w_push   = w_wr_data && (!r_full || w_pop);
  assign w_drop   = w_wr_data && r_full && !w_pop;
  assign w_wr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt = r_rd_ptr + PW'(w_pop);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  assign TX          = r_tx;
  assign BUSY        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
  assign bus.STATUS  = {4'b0000, r_ovf, BUSY, r_full, r_empty};

  // FIFO storage; the slot is written only on an accepted push.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.OUT_PORT;
  end

  // Strobe history, FIFO pointers, registered FULL/EMPTY and the sticky overflow flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_strb_q <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_strb_q <= bus.IO_STRB;
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      r_full   <= (w_wr_nxt[PW-1] != w_rd_nxt[PW-1]) &&
                  (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      // A set wins over a clear in the same cycle.
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_wr_stat) r_ovf <= 1'b0;
    end
  end

  // Frame FSM: start bit, eight data bits sent LSB first, stop bit, and back-to-back frames while data is waiting.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_shift <= 8'h00;
      r_bit   <= 3'd0;
      r_baud  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= 16'd0;
          r_bit  <= 3'd0;
          r_tx   <= 1'b1;
          if (!r_empty) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= 16'd0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= 16'd0;
            r_bit  <= 3'd0;
            if (!r_empty) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_baud  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arduino_uart_tx.sv
// Bench for arduino_uart_tx. A queue-level model tracks FIFO contents,
// remaining frame time and the overflow flag. A UART monitor decodes TX
// frames and checks them against the expected-byte queue.
module tb_arduino_uart_tx;
  localparam int         CPB   = 4;
  localparam int         DEPTH = 8;
  localparam logic [7:0] DID   = 8'h22;
  localparam logic [7:0] SID   = 8'h23;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TX;
  logic       BUSY;
  logic [1:0] dbg_state;

  arduino_uart_tx_if bus();

  arduino_uart_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_ID(DID), .STATUS_ID(SID)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus), .TX(TX), .BUSY(BUSY), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         m_left;
  bit         m_ovf;
  bit         m_strb_q;
  bit         m_pop;
  bit         m_evt;
  logic [7:0] m_tmp;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_fifo.delete();
      exp_q.delete();
      m_left   = 0;
      m_ovf    = 0;
      m_strb_q = 0;
    end else begin
      if (m_left > 0) m_left--;
      m_pop = (m_left == 0) && (m_fifo.size() > 0);
      if (m_pop) begin
        m_tmp  = m_fifo.pop_front();
        m_left = 10 * CPB;
      end
      m_evt    = bus.IO_STRB && !m_strb_q;
      m_strb_q = bus.IO_STRB;
      if (m_evt && bus.PORT_ID == DID) begin
        if (m_fifo.size() < DEPTH) begin
          m_fifo.push_back(bus.OUT_PORT);
          exp_q.push_back(bus.OUT_PORT);
        end else begin
          m_ovf = 1;
        end
      end else if (m_evt && bus.PORT_ID == SID) begin
        m_ovf = 0;
      end
    end
  end

  // Status, busy and idle-line checks against the model, once per cycle.
  logic [7:0] exp_status;
  always @(negedge CLK) begin
    if (chk_en && RESET_N) begin
      exp_status = {4'b0000, m_ovf, (m_left > 0), (m_fifo.size() == DEPTH), (m_fifo.size() == 0)};
      check("status", bus.STATUS, exp_status);
      check("busy", {7'b0, BUSY}, {7'b0, (m_left > 0)});
      if (m_left == 0) check("tx_idle", {7'b0, TX}, 8'h01);
    end
  end

  // ---------------- UART monitor ----------------
  logic [7:0] mon_byte;
  logic       mon_stop;
  bit         mon_abort;
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET_N && TX == 1'b0) begin
        mon_abort = 0;
        mon_byte  = 8'h00;
        mon_stop  = 1'b0;
        for (int n = 1; n <= 9 * CPB + CPB / 2; n++) begin
          @(negedge CLK);
          if (!RESET_N) mon_abort = 1;
          if (n == CPB / 2 && !mon_abort) check("start_bit", {7'b0, TX}, 8'h00);
          if (n >= CPB + CPB / 2 && ((n - CPB / 2) % CPB) == 0) begin
            if ((n - CPB / 2) / CPB - 1 < 8) mon_byte[(n - CPB / 2) / CPB - 1] = TX;
            else mon_stop = TX;
          end
        end
        if (!mon_abort) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %02h expected no frame", mon_byte);
          end else begin
            check("tx_byte", mon_byte, exp_q.pop_front());
          end
          check("stop_bit", {7'b0, mon_stop}, 8'h01);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds the strobe for len cycles, then low for gap (>=1) cycles.
  task automatic wr(input logic [7:0] id, input logic [7:0] d, input int len, input int gap);
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    bus.IO_STRB  = 1'b1;
    repeat (len) @(negedge CLK);
    bus.IO_STRB = 1'b0;
    repeat ((gap < 1) ? 1 : gap) @(negedge CLK);
  endtask

  task automatic wait_idle(input int max_cycles);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || m_left != 0 || m_fifo.size() != 0) && c < max_cycles) begin
      @(negedge CLK);
      c++;
    end
    total++;
    if (c >= max_cycles) begin
      bad++;
      $display("FAIL drain: %0d bytes pending after %0d cycles, expected 0", exp_q.size(), c);
    end
  endtask

  // ---------------- stimulus ----------------
  int c;
  initial begin
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    RESET_N      = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_status", bus.STATUS, 8'h01);
    check("reset_tx", {7'b0, TX}, 8'h01);
    check("reset_busy", {7'b0, BUSY}, 8'h00);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk_en = 1'b1;

    // Single A5 frame; strobe held for two cycles.
    bus.PORT_ID  = DID;
    bus.OUT_PORT = 8'hA5;
    bus.IO_STRB  = 1'b1;
    @(negedge CLK);
    check("tx_after_push_edge", {7'b0, TX}, 8'h01);
    @(negedge CLK);
    bus.IO_STRB = 1'b0;
    check("tx_low_second_edge", {7'b0, TX}, 8'h00);
    wait_idle(100);
    check("status_after_a5", bus.STATUS, 8'h01);

    // Three back-to-back writes.
    wr(DID, 8'h01, 1, 1);
    wr(DID, 8'h02, 1, 1);
    wr(DID, 8'h03, 1, 1);
    wait_idle(300);

    // Ten writes during the first frame: one in shifter, eight buffered, one dropped.
    for (int i = 0; i < 10; i++) wr(DID, 8'($urandom_range(0, 255)), 1, 1);
    check("full_overflow", bus.STATUS, 8'h0E);
    wr(SID, 8'h00, 1, 1);
    check("overflow_cleared", bus.STATUS, 8'h06);
    wr(8'h40, 8'h77, 1, 1);
    wr(8'h40, 8'h78, 2, 1);
    check("other_port_ignored", bus.STATUS, 8'h06);

    // Push into a full FIFO on the same edge as the stop-end pop.
    c = 0;
    while (!(m_left == 1 && m_fifo.size() == DEPTH) && c < 200) begin
      @(negedge CLK);
      c++;
    end
    total++;
    if (c >= 200) begin
      bad++;
      $display("FAIL stop_pop_wait: waited %0d cycles, expected stop-end with full FIFO", c);
    end
    wr(DID, 8'hC3, 1, 1);
    check("push_at_stop_pop", bus.STATUS, 8'h06);
    wait_idle(1000);

    // Reset in the middle of data bit 3 with bytes still queued.
    wr(DID, 8'h5A, 1, 1);
    wr(DID, 8'h3C, 1, 1);
    wr(DID, 8'h99, 1, 1);
    repeat (13) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("midframe_reset_tx", {7'b0, TX}, 8'h01);
    check("midframe_reset_busy", {7'b0, BUSY}, 8'h00);
    check("midframe_reset_status", bus.STATUS, 8'h01);
    check("midframe_reset_state", {6'b0, dbg_state}, 8'h00);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (60) @(negedge CLK);

    // Randomized traffic across data, status and foreign port IDs.
    for (int i = 0; i < 150; i++) begin
      int sel;
      logic [7:0] id;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      id = DID;
      else if (sel == 7) id = SID;
      else if (sel == 8) id = 8'h40;
      else               id = 8'($urandom_range(0, 255));
      wr(id, 8'($urandom_range(0, 255)), $urandom_range(1, 3), $urandom_range(1, 12));
    end
    wait_idle(10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
